// File: rtl/trace_pkg.sv
// Shared types and defaults for the on-chip trace checker.
// The optional per-bit compare mask is enabled by defining TRACE_CHECKER_MASK_EN.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF  = 32;
    localparam int NUM_CH_DEF = 3;
    localparam int DEPTH_DEF  = 64;
    localparam int ERR_W_DEF  = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_vec_mem.sv
// One channel of the expected-vector table: register array with a synchronous
// write port and a combinational read port. Contents are not reset.
module trace_vec_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_checker.sv
// Trace checker: compares sampled datapath vectors against a loaded table and
// accumulates mismatch statistics. Define TRACE_CHECKER_MASK_EN for per-bit masks.
module trace_checker
    import trace_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ERR_W  = ERR_W_DEF,
    localparam int AW    = clog2(DEPTH),
    localparam int CHW   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_we,
    input  logic [AW-1:0]           load_addr,
    input  logic [CHW-1:0]          load_ch,
    input  logic [WIDTH-1:0]        load_data,
`ifdef TRACE_CHECKER_MASK_EN
    input  logic [WIDTH-1:0]        load_mask,
`endif
    input  logic                    start,
    input  logic [AW:0]             num_vec,
    input  logic                    sample,
    input  logic [NUM_CH*WIDTH-1:0] obs,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    mismatch,
    output logic [ERR_W-1:0]        err_count,
    output logic                    first_err_valid,
    output logic [AW-1:0]           first_err_idx,
    output logic [CHW-1:0]          first_err_ch,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = clog2(NUM_CH + 1);
    localparam int SUM_W = ERR_W + CNT_W;

    state_t           state_q;
    logic [AW:0]      count_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q, done_q, pass_q, mismatch_q, fv_q;
    logic [ERR_W-1:0] err_q;
    logic [AW-1:0]    fi_q;
    logic [CHW-1:0]   fc_q;

    logic [WIDTH-1:0] exp_rd [NUM_CH];
    logic [WIDTH-1:0] msk_rd [NUM_CH];
    logic [NUM_CH-1:0] diff;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic we_c;
        assign we_c = load_we && (state_q != RUN) && (load_ch == CHW'(c));

        trace_vec_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_exp (
            .clock (clock),
            .we    (we_c),
            .waddr (load_addr),
            .wdata (load_data),
            .raddr (idx_q),
            .rdata (exp_rd[c])
        );
`ifdef TRACE_CHECKER_MASK_EN
        trace_vec_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_msk (
            .clock (clock),
            .we    (we_c),
            .waddr (load_addr),
            .wdata (load_mask),
            .raddr (idx_q),
            .rdata (msk_rd[c])
        );
`else
        assign msk_rd[c] = '1;
`endif
        assign diff[c] = |((obs[c*WIDTH +: WIDTH] ^ exp_rd[c]) & msk_rd[c]);
    end

    logic [CNT_W-1:0] nmis;
    logic [CHW-1:0]   low_ch;
    logic [SUM_W-1:0] sum;
    logic [ERR_W-1:0] err_next;
    logic [AW:0]      start_count;
    logic             last;

    always_comb begin
        nmis   = '0;
        low_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nmis = nmis + CNT_W'(diff[c]);
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (diff[c]) low_ch = CHW'(c);
        end
        // Widened add so the saturation check cannot itself overflow.
        sum         = SUM_W'(err_q) + SUM_W'(nmis);
        err_next    = (sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
        start_count = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
        last        = ({1'b0, idx_q} == count_q - 1'b1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            fv_q       <= 1'b0;
            fi_q       <= '0;
            fc_q       <= '0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        count_q <= start_count;
                        idx_q   <= '0;
                        err_q   <= '0;
                        fv_q    <= 1'b0;
                        fi_q    <= '0;
                        fc_q    <= '0;
                        busy_q  <= (start_count != '0);
                        done_q  <= (start_count == '0);
                        pass_q  <= (start_count == '0);
                        state_q <= (start_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (sample) begin
                        err_q      <= err_next;
                        mismatch_q <= |diff;
                        if (|diff && !fv_q) begin
                            fv_q <= 1'b1;
                            fi_q <= idx_q;
                            fc_q <= low_ch;
                        end
                        idx_q <= idx_q + 1'b1;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_next == '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatch        = mismatch_q;
    assign err_count       = err_q;
    assign first_err_valid = fv_q;
    assign first_err_idx   = fi_q;
    assign first_err_ch    = fc_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_trace_checker.sv
// Randomized self-checking bench for trace_checker against a behavioural table model.
// Honors TRACE_CHECKER_MASK_EN the same way the design does.
module tb_trace_checker;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 3;
    localparam int DEPTH  = 64;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    load_we = 1'b0;
    logic [5:0]              load_addr = '0;
    logic [1:0]              load_ch = '0;
    logic [WIDTH-1:0]        load_data = '0;
    logic [WIDTH-1:0]        load_mask = '1;
    logic                    start = 1'b0;
    logic [6:0]              num_vec = '0;
    logic                    sample = 1'b0;
    logic [NUM_CH*WIDTH-1:0] obs = '0;

    logic        busy, done, pass, mismatch, fev;
    logic [15:0] err_count;
    logic [5:0]  fei;
    logic [1:0]  fec, dbg_state;
    logic        s_busy, s_done, s_pass, s_mismatch, s_fev;
    logic [1:0]  s_err;
    logic [5:0]  s_fei;
    logic [1:0]  s_fec, s_state;

    always #5 clock = ~clock;

    trace_checker #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ERR_W(16)) dut (
        .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_ch(load_ch), .load_data(load_data),
`ifdef TRACE_CHECKER_MASK_EN
        .load_mask(load_mask),
`endif
        .start(start), .num_vec(num_vec), .sample(sample), .obs(obs),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .err_count(err_count), .first_err_valid(fev), .first_err_idx(fei),
        .first_err_ch(fec), .dbg_state(dbg_state)
    );

    trace_checker #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_ch(load_ch), .load_data(load_data),
`ifdef TRACE_CHECKER_MASK_EN
        .load_mask(load_mask),
`endif
        .start(start), .num_vec(num_vec), .sample(sample), .obs(obs),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
        .err_count(s_err), .first_err_valid(s_fev), .first_err_idx(s_fei),
        .first_err_ch(s_fec), .dbg_state(s_state)
    );

    // Reference model: table contents plus run bookkeeping (0 idle, 1 run, 2 done).
    logic [WIDTH-1:0] tbl [DEPTH][NUM_CH];
    logic [WIDTH-1:0] msk [DEPTH][NUM_CH];
    int m_state, m_count, m_idx, m_err, m_fi, m_fc;
    bit m_fv;
    logic [15:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [NUM_CH*WIDTH-1:0] vec(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] c);
        return {c, b, a};
    endfunction

    task automatic check_all(input string tag, input bit exp_mis);
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'(sat(m_err, 65535));
        check({tag, ".mismatch"}, mismatch, exp_mis);
        check({tag, ".err"}, err_count, e);
        check({tag, ".err_sat"}, s_err, sat(m_err, 3));
        check({tag, ".busy"}, busy, m_state == 1);
        check({tag, ".done"}, done, m_state == 2);
        check({tag, ".pass"}, pass, (m_state == 2) && (m_err == 0));
        check({tag, ".fev"}, fev, m_fv);
        check({tag, ".fei"}, fei, m_fv ? m_fi : 0);
        check({tag, ".fec"}, fec, m_fv ? m_fc : 0);
        check({tag, ".state"}, dbg_state, m_state);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_state = 0; m_count = 0; m_idx = 0; m_err = 0; m_fv = 0; m_fi = 0; m_fc = 0;
        exp_q.delete();
        check_all("reset", 1'b0);
        check("reset.sat_state", s_state, 0);
    endtask

    task automatic load(input int a, input int c, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] mk);
        load_we = 1'b1; load_addr = 6'(a); load_ch = 2'(c); load_data = d; load_mask = mk;
        @(posedge clock); #1;
        load_we = 1'b0;
        if (m_state != 1 && c < NUM_CH) begin
            tbl[a][c] = d;
`ifdef TRACE_CHECKER_MASK_EN
            msk[a][c] = mk;
`else
            msk[a][c] = '1;
`endif
        end
    endtask

    task automatic load_vec(input int a, input logic [NUM_CH*WIDTH-1:0] v,
                            input logic [NUM_CH*WIDTH-1:0] mk);
        for (int c = 0; c < NUM_CH; c++) load(a, c, v[c*WIDTH +: WIDTH], mk[c*WIDTH +: WIDTH]);
    endtask

    task automatic start_run(input string tag, input int nv);
        bit was_run;
        was_run = (m_state == 1);
        start = 1'b1; num_vec = 7'(nv);
        @(posedge clock); #1;
        start = 1'b0;
        if (!was_run) begin
            m_count = sat(nv, DEPTH);
            m_idx = 0; m_err = 0; m_fv = 0; m_fi = 0; m_fc = 0;
            m_state = (m_count == 0) ? 2 : 1;
        end
        check_all(tag, 1'b0);
    endtask

    task automatic do_sample(input string tag, input logic [NUM_CH*WIDTH-1:0] v);
        int nm, lowc;
        bit running;
        running = (m_state == 1);
        sample = 1'b1; obs = v;
        @(posedge clock); #1;
        sample = 1'b0;
        nm = 0; lowc = -1;
        if (running) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (((v[c*WIDTH +: WIDTH] ^ tbl[m_idx][c]) & msk[m_idx][c]) != 0) begin
                    nm++;
                    if (lowc < 0) lowc = c;
                end
            end
            m_err += nm;
            if (nm > 0 && !m_fv) begin m_fv = 1; m_fi = m_idx; m_fc = lowc; end
            m_idx++;
            if (m_idx == m_count) m_state = 2;
        end
        exp_q.push_back(16'(sat(m_err, 65535)));
        check_all(tag, nm > 0);
    endtask

    logic [NUM_CH*WIDTH-1:0] v0, v1, v2, ones, rv;

    initial begin
        v0   = vec(32'h28400005, 32'd0, 32'd5);
        v1   = vec(32'h28800003, 32'd0, 32'd3);
        v2   = vec(32'h00C22000, 32'd5, 32'd3);
        ones = '1;

        @(posedge clock); #1;
        do_reset();

        load_vec(0, v0, ones); load_vec(1, v1, ones); load_vec(2, v2, ones);

        // Exact replay passes.
        start_run("exact.start", 3);
        do_sample("exact.s0", v0); do_sample("exact.s1", v1); do_sample("exact.s2", v2);
        check("exact.pass_const", pass, 1'b1);
        @(posedge clock); #1;
        check_all("exact.idle", 1'b0);

        // Corrupted run; also a load and a start while running must be ignored.
        start_run("corrupt.start", 3);
        do_sample("corrupt.s0", v0);
        load(1, 0, 32'hFFFFFFFF, '1);
        check_all("load_in_run", 1'b0);
        start_run("start_in_run", 5);
        do_sample("corrupt.s1", vec(32'h28800003, 32'd0, 32'd4));
        do_sample("corrupt.s2", vec(32'h11111111, 32'd7, 32'd3));
        check("corrupt.err_const", err_count, 3);
        check("corrupt.fei_const", fei, 1);
        check("corrupt.fec_const", fec, 2);

        // All channels wrong: narrow counter saturates.
        start_run("allbad.start", 3);
        do_sample("allbad.s0", ~v0); do_sample("allbad.s1", ~v1); do_sample("allbad.s2", ~v2);
        check("allbad.sat_const", s_err, 3);

        // Reset mid-run, then rerun with the table intact.
        start_run("midrst.start", 3);
        do_sample("midrst.s0", ~v0);
        do_reset();
        start_run("rerun.start", 3);
        do_sample("rerun.s0", v0); do_sample("rerun.s1", v1); do_sample("rerun.s2", v2);

        // Zero-length run.
        start_run("zero.start", 0);
        check("zero.pass_const", pass, 1'b1);

        // Full random table, oversized request clamps to DEPTH.
        for (int a = 0; a < DEPTH; a++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                load(a, c, $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFFFFFF);
            end
        end
        start_run("rand.start", DEPTH + 5);
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rv[c*WIDTH +: WIDTH] = tbl[i][c];
                if ($urandom_range(0, 2) == 0) rv[c*WIDTH +: WIDTH] ^= (32'd1 << $urandom_range(0, 31));
            end
            do_sample($sformatf("rand.s%0d", i), rv);
        end
        check("rand.done_const", done, 1'b1);
        do_sample("rand.after_done", ~rv);

        // Masked channel 1 treated as don't-care when masks exist.
        load_vec(0, v0, vec('1, '0, '1)); load_vec(1, v1, vec('1, '0, '1));
        load_vec(2, v2, vec('1, '0, '1));
        start_run("mask.start", 3);
        do_sample("mask.s0", vec(32'h28400005, 32'hDEADBEEF, 32'd5));
        do_sample("mask.s1", vec(32'h28800003, 32'hDEADBEEF, 32'd3));
        do_sample("mask.s2", vec(32'h00C22000, 32'hDEADBEEF, 32'd3));
`ifdef TRACE_CHECKER_MASK_EN
        check("mask.err_const", err_count, 0);
`else
        check("mask.err_const", err_count, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
